// File: rtl/ultrasonic_axi_phase_regs.sv
// AXI4-Lite register bank for the phased-array PWM core: shadow period/phases, atomic copy to active on period_tick.
// Define COMMIT_IRQ_EN to latch an interrupt flag on each commit (cleared by writing 1 to STATUS[1]).
module ultrasonic_axi_phase_regs #(
  parameter int NUM_CH             = 16,
  parameter int PHASE_W            = 10,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0]                    s00_axi_awprot,
  input  logic                          s00_axi_awvalid,
  output logic                          s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
  input  logic [3:0]                    s00_axi_wstrb,
  input  logic                          s00_axi_wvalid,
  output logic                          s00_axi_wready,
  output logic [1:0]                    s00_axi_bresp,
  output logic                          s00_axi_bvalid,
  input  logic                          s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0]                    s00_axi_arprot,
  input  logic                          s00_axi_arvalid,
  output logic                          s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
  output logic [1:0]                    s00_axi_rresp,
  output logic                          s00_axi_rvalid,
  input  logic                          s00_axi_rready,
  input  logic                          period_tick,
  output logic                          pwm_enable,
  output logic [PHASE_W-1:0]            pwm_period,
  output logic [NUM_CH*PHASE_W-1:0]     pwm_phase,
  output logic                          commit_done,
  output logic                          irq
);

  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_PERIOD = WORD_W'(2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                      r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                r_bresp, r_rresp;
  logic [31:0]               r_rdata;
  logic                      r_enable, r_pending, r_commit_done;
  logic [PHASE_W-1:0]        r_period_sh, r_period_act;
  logic [NUM_CH*PHASE_W-1:0] w_phase_sh_flat;
  logic [NUM_CH*PHASE_W-1:0] w_phase_act_flat;
  logic [NUM_CH-1:0]         w_aw_ph_hit;
  logic [WORD_W-1:0]         w_aw_word, w_ar_word;
  logic                      w_wr_fire, w_rd_fire, w_copy, w_commit_set, w_aw_hit;
  logic                      w_aw_ctrl, w_aw_status, w_aw_period;
  logic                      w_irq_flag;
  logic [31:0]               w_rdata_next;
  logic [1:0]                w_rresp_next;
  logic                      w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                      s00_axi_araddr[1:0], s00_axi_wdata[31:PHASE_W]};

  // Byte-strobe merge restricted to the implemented field width.
  function automatic logic [PHASE_W-1:0] f_merge(input logic [PHASE_W-1:0] old_v,
                                                 input logic [31:0] data,
                                                 input logic [3:0] strb);
    logic [PHASE_W-1:0] res;
    for (int k = 0; k < PHASE_W; k++) res[k] = strb[k/8] ? data[k] : old_v[k];
    return res;
  endfunction

  assign w_aw_word    = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_word    = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_aw_ctrl    = (w_aw_word == W_CTRL);
  assign w_aw_status  = (w_aw_word == W_STATUS);
  assign w_aw_period  = (w_aw_word == W_PERIOD);
  assign w_aw_hit     = w_aw_ctrl | w_aw_status | w_aw_period | (|w_aw_ph_hit);
  assign w_wr_fire    = r_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd_fire    = r_arready & s00_axi_arvalid;
  assign w_commit_set = w_wr_fire & w_aw_ctrl & s00_axi_wstrb[0] & s00_axi_wdata[1];
  assign w_copy       = period_tick & r_pending;

  // Write channel: ready is a one-cycle pulse, only while no response is outstanding.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_awready <= ~r_awready & s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_enable      <= 1'b0;
      r_pending     <= 1'b0;
      r_commit_done <= 1'b0;
      r_period_sh   <= '0;
      r_period_act  <= '0;
    end else begin
      r_commit_done <= w_copy;
      if (w_wr_fire && w_aw_ctrl && s00_axi_wstrb[0]) r_enable <= s00_axi_wdata[0];
      if (w_wr_fire && w_aw_period)
        r_period_sh <= f_merge(r_period_sh, s00_axi_wdata, s00_axi_wstrb);
      if (w_copy) begin
        r_period_act <= r_period_sh;
        r_pending    <= 1'b0;
      end
      // A commit request landing on the copy edge stays pending for the next tick.
      if (w_commit_set) r_pending <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_phase
      logic [PHASE_W-1:0] r_sh, r_act;
      assign w_aw_ph_hit[gi] = (w_aw_word == WORD_W'(4 + gi));
      always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
          r_sh  <= '0;
          r_act <= '0;
        end else begin
          if (w_wr_fire && w_aw_ph_hit[gi]) r_sh <= f_merge(r_sh, s00_axi_wdata, s00_axi_wstrb);
          if (w_copy) r_act <= r_sh;
        end
      end
      assign w_phase_sh_flat[gi*PHASE_W +: PHASE_W]  = r_sh;
      assign w_phase_act_flat[gi*PHASE_W +: PHASE_W] = r_act;
    end
  endgenerate

`ifdef COMMIT_IRQ_EN
  logic r_irq_flag;
  logic w_status_w1c;
  assign w_status_w1c = w_wr_fire & w_aw_status & s00_axi_wstrb[0] & s00_axi_wdata[1];
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)     r_irq_flag <= 1'b0;
    else if (r_commit_done)   r_irq_flag <= 1'b1;
    else if (w_status_w1c)    r_irq_flag <= 1'b0;
  end
  assign w_irq_flag = r_irq_flag;
`else
  assign w_irq_flag = 1'b0;
`endif

  always_comb begin
    w_rdata_next = '0;
    w_rresp_next = RESP_SLVERR;
    if (w_ar_word == W_CTRL) begin
      w_rdata_next = {31'b0, r_enable};
      w_rresp_next = RESP_OKAY;
    end else if (w_ar_word == W_STATUS) begin
      w_rdata_next = {16'b0, 8'(NUM_CH), 6'b0, w_irq_flag, r_pending};
      w_rresp_next = RESP_OKAY;
    end else if (w_ar_word == W_PERIOD) begin
      w_rdata_next = 32'(r_period_sh);
      w_rresp_next = RESP_OKAY;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ar_word == WORD_W'(4 + i)) begin
        w_rdata_next = 32'(w_phase_sh_flat[i*PHASE_W +: PHASE_W]);
        w_rresp_next = RESP_OKAY;
      end
    end
  end

  // Read data is captured on the address handshake and held until rready.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= ~r_arready & s00_axi_arvalid & ~r_rvalid;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_next;
        r_rresp  <= w_rresp_next;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = r_rresp;
  assign pwm_enable      = r_enable;
  assign pwm_period      = r_period_act;
  assign pwm_phase       = w_phase_act_flat;
  assign commit_done     = r_commit_done;
  assign irq             = w_irq_flag;

endmodule

// File: tb/tb_ultrasonic_axi_phase_regs.sv
// Directed bench for ultrasonic_axi_phase_regs: vector table of AXI accesses plus hand-written commit/handshake sequences.
module tb_ultrasonic_axi_phase_regs;
  localparam int NUM_CH = 16;
  localparam int PW     = 10;
`ifdef COMMIT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        period_tick = 0;
  logic        pwm_enable, commit_done, irq;
  logic [PW-1:0]        pwm_period;
  logic [NUM_CH*PW-1:0] pwm_phase;

  int checks = 0, errors = 0;
  logic [1:0]  got_resp;
  logic [31:0] got_data;

  always #5 clk = ~clk;

  ultrasonic_axi_phase_regs dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .period_tick(period_tick), .pwm_enable(pwm_enable), .pwm_period(pwm_period),
    .pwm_phase(pwm_phase), .commit_done(commit_done), .irq(irq)
  );

  typedef struct {
    string       name;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout got none expected handshake", name);
  endtask

  task automatic wr_start(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bit seen = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (awready && wready) seen = 1;
    end
    if (!seen) timeout("awready");
  endtask

  task automatic wr_edge();
    @(posedge clk);
    #1 awvalid = 0; wvalid = 0;
  endtask

  task automatic wr_resp();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bvalid) seen = 1;
    end
    if (!seen) timeout("bvalid");
    got_resp = bresp;
    bready = 1;
    @(posedge clk);
    #1 bready = 0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_start(a, d, s);
    wr_edge();
    wr_resp();
  endtask

  task automatic axi_read(input logic [7:0] a);
    bit seen = 0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (arready) seen = 1;
    end
    if (!seen) timeout("arready");
    @(posedge clk);
    #1 arvalid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    if (!seen) timeout("rvalid");
    got_data = rdata;
    got_resp = rresp;
    rready = 1;
    @(posedge clk);
    #1 rready = 0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    period_tick = 1;
    @(negedge clk);
    period_tick = 0;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"rd_status_rst", 0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h0000_1000});
    vecs.push_back('{"rd_ctrl_rst",   0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h0});
    vecs.push_back('{"wr_period",     1, 8'h08, 32'h3E8,      4'hF, 2'b00, 32'h0});
    vecs.push_back('{"wr_ph0",        1, 8'h10, 32'h123,      4'hF, 2'b00, 32'h0});
    vecs.push_back('{"rd_period",     0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h3E8});
    vecs.push_back('{"rd_ph0",        0, 8'h10, 32'h0,        4'h0, 2'b00, 32'h123});
    vecs.push_back('{"wr_ph15",       1, 8'h4C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{"rd_ph15",       0, 8'h4C, 32'h0,        4'h0, 2'b00, 32'h3FF});
    vecs.push_back('{"wr_ph1_b0",     1, 8'h14, 32'hFFFF_FABC, 4'h1, 2'b00, 32'h0});
    vecs.push_back('{"rd_ph1_b0",     0, 8'h14, 32'h0,        4'h0, 2'b00, 32'h0BC});
    vecs.push_back('{"wr_ph1_b1",     1, 8'h15, 32'h0000_0200, 4'h2, 2'b00, 32'h0});
    vecs.push_back('{"rd_ph1_b1",     0, 8'h14, 32'h0,        4'h0, 2'b00, 32'h2BC});
    vecs.push_back('{"rd_0x50",       0, 8'h50, 32'h0,        4'h0, 2'b10, 32'h0});
    vecs.push_back('{"rd_0x0c",       0, 8'h0C, 32'h0,        4'h0, 2'b10, 32'h0});
    vecs.push_back('{"rd_0xfc",       0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h0});
    vecs.push_back('{"wr_0xfc",       1, 8'hFC, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0});
    vecs.push_back('{"rd_period_aft", 0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h3E8});
    vecs.push_back('{"wr_ctrl_en",    1, 8'h00, 32'h1,        4'hF, 2'b00, 32'h0});
    vecs.push_back('{"rd_ctrl_en",    0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h1});

    repeat (3) @(negedge clk);
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_bvalid",  {31'b0, bvalid}, 0);
    chk("rst_rvalid",  {31'b0, rvalid}, 0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_period",  32'(pwm_period), 0);
    chk("rst_phase_or", {31'b0, |pwm_phase}, 0);
    chk("rst_misc",    {29'b0, pwm_enable, commit_done, irq}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
        chk({vecs[i].name, "_bresp"}, 32'(got_resp), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr);
        chk({vecs[i].name, "_rdata"}, got_data, vecs[i].rdata);
        chk({vecs[i].name, "_rresp"}, 32'(got_resp), 32'(vecs[i].resp));
      end
    end
    chk("no_tick_period", 32'(pwm_period), 0);
    chk("no_tick_ph0",    32'(pwm_phase[0 +: PW]), 0);
    chk("enable_out",     {31'b0, pwm_enable}, 1);

    // Commit on a tick
    axi_write(8'h00, 32'h3, 4'hF);
    axi_read(8'h04);
    chk("status_pending", got_data, 32'h0000_1001);
    pulse_tick();
    chk("commit_done_hi", {31'b0, commit_done}, 1);
    chk("act_period",  32'(pwm_period), 32'h3E8);
    chk("act_ph0",     32'(pwm_phase[0 +: PW]), 32'h123);
    chk("act_ph1",     32'(pwm_phase[1*PW +: PW]), 32'h2BC);
    chk("act_ph15",    32'(pwm_phase[15*PW +: PW]), 32'h3FF);
    @(negedge clk);
    chk("commit_done_lo", {31'b0, commit_done}, 0);
    chk("irq_after_commit", {31'b0, irq}, {31'b0, IRQ_EN});
    axi_read(8'h04);
    chk("status_after_commit", got_data, IRQ_EN ? 32'h0000_1002 : 32'h0000_1000);
    axi_write(8'h04, 32'h2, 4'hF);
    chk("status_w1c_bresp", 32'(got_resp), 0);
    @(negedge clk);
    chk("irq_cleared", {31'b0, irq}, 0);

    // Commit write coincident with tick: no copy on that tick
    axi_write(8'h08, 32'h1F4, 4'hF);
    wr_start(8'h00, 32'h3, 4'hF);
    period_tick = 1;
    wr_edge();
    period_tick = 0;
    @(negedge clk);
    chk("coinc_no_done", {31'b0, commit_done}, 0);
    chk("coinc_no_copy", 32'(pwm_period), 32'h3E8);
    wr_resp();
    axi_read(8'h04);
    chk("coinc_pending", got_data, 32'h0000_1001);
    axi_write(8'h08, 32'h1F5, 4'hF);
    axi_write(8'h00, 32'h3, 4'hF);
    pulse_tick();
    chk("coinc_done", {31'b0, commit_done}, 1);
    chk("coinc_copy_latest", 32'(pwm_period), 32'h1F5);
    axi_read(8'h04);
    chk("coinc_pending_clr", got_data & 32'h1, 0);
    pulse_tick();
    chk("idle_tick_no_done", {31'b0, commit_done}, 0);

    // AW ahead of W by 5 cycles, bready held low for 3 cycles
    @(negedge clk);
    awaddr = 8'h10; awvalid = 1; wstrb = 4'hF; wdata = 32'h055;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("aw_only_ready_c%0d", i), {31'b0, awready | wready}, 0);
    end
    wvalid = 1;
    wr_start(8'h10, 32'h055, 4'hF);
    wr_edge();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bhold_c%0d", i), {29'b0, bvalid, bresp}, 32'h4);
      @(negedge clk);
    end
    bready = 1;
    @(posedge clk); #1 bready = 0;
    @(negedge clk);
    chk("bvalid_dropped", {31'b0, bvalid}, 0);
    axi_read(8'h10);
    chk("late_w_rdata", got_data, 32'h055);

    // Reset in the middle of a write
    @(negedge clk);
    awaddr = 8'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_awready", {31'b0, awready}, 0);
    chk("midrst_period", 32'(pwm_period), 0);
    chk("midrst_enable", {31'b0, pwm_enable}, 0);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_b_c%0d", i), {31'b0, bvalid}, 0);
    end
    axi_read(8'h08);
    chk("midrst_shadow", got_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
